// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the byte-queue control blocks.
package fifo_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_DW      = 8;
    localparam int QUEUE_DEPTH = 256;
    localparam int STALL_W     = 16;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin search: first valid index strictly after 'last',
// wrapping modulo N (not modulo 2^IW).
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand [N];

    // cand[k] = (last + k + 1) mod N; last < N so one conditional subtract suffices
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum       = {1'b0, last} + (IW+1)'(gi + 1);
            assign cand[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        idx   = last;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[cand[k]]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of the byte queue write port among
// N_REQ producers, plus ce-gated read strobe for the consumer drain request.
module fifo_write_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = DEF_DW,
    parameter int BURST = 4,
    parameter int OW    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*DW-1:0]  req_data,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    output logic                 fifo_wr_en,
    output logic [DW-1:0]        fifo_wr_data,
    input  logic                 drain_req,
    output logic                 fifo_rd_en,
    output logic [OW-1:0]        owner,
    output logic                 busy,
    output logic [STALL_W-1:0]   stall_cnt
);

    localparam int BW = $clog2(BURST) + 1;

    state_t               state_q, state_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [STALL_W-1:0]   stall_q, stall_d;

    logic [DW-1:0]        data_arr [N_REQ];
    logic                 pick_found;
    logic [OW-1:0]        pick_idx;
    logic                 owner_valid;
    logic                 last_beat;
    logic                 accept;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    rr_pick #(
        .N  (N_REQ),
        .IW (OW)
    ) u_pick (
        .valid (req_valid),
        .last  (owner_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_valid = req_valid[owner_q];
    assign last_beat   = (beat_q == BW'(BURST - 1));
    // rst gating keeps the strobes quiet in a reset cycle that lands mid-burst
    assign accept      = ~rst & ce & (state_q == GRANT) & owner_valid & ~fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OW'(N_REQ - 1);
            beat_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        stall_d = stall_q;
        if (ce) begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        owner_d = pick_idx;
                        beat_d  = '0;
                        state_d = GRANT;
                    end
                end
                GRANT: begin
                    // owner is kept on release so the next search starts past it
                    if (!owner_valid) begin
                        state_d = IDLE;
                    end else if (fifo_full) begin
                        if (stall_q != '1) begin
                            stall_d = stall_q + STALL_W'(1);
                        end
                    end else if (last_beat) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        fifo_wr_en = 1'b0;
        if (accept) begin
            req_ready[owner_q] = 1'b1;
            fifo_wr_en         = 1'b1;
        end
        fifo_wr_data = data_arr[owner_q];
        fifo_rd_en   = ~rst & ce & drain_req & ~fifo_empty;
        busy         = (state_q == GRANT);
        owner        = owner_q;
        stall_cnt    = stall_q;
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomised and directed bench for fifo_write_arbiter against a queue-level model.
module tb_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            ce;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic            drain_req;
    logic            fifo_rd_en;
    logic [1:0]      owner;
    logic            busy;
    logic [15:0]     stall_cnt;

    fifo_write_arbiter #(
        .N_REQ (N),
        .DW    (DW),
        .BURST (BURST),
        .OW    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .drain_req    (drain_req),
        .fifo_rd_en   (fifo_rd_en),
        .owner        (owner),
        .busy         (busy),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_idx = 0;
    int ce_per = 1;

    // per-producer word sources (circular buffers)
    logic [7:0] pbuf [N][64];
    int  head [N];
    int  tail [N];
    bit  en [N];

    // behavioural model: who owns the port, beats taken, stall ticks
    bit  m_busy;
    int  m_owner;
    int  m_beats;
    int  m_stall;
    int  exp_acc;

    typedef struct {
        int owner;
        int data;
        int tick;
    } wr_t;
    wr_t wr_log[$];
    bit  both_seen;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push(input int p, input int v);
        pbuf[p][tail[p] % 64] = 8'(v);
        tail[p]++;
    endtask

    task automatic clear_prod();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            en[i]   = 1'b1;
        end
    endtask

    function automatic int log_owner(input int j);
        return (j < wr_log.size()) ? wr_log[j].owner : -1;
    endfunction

    function automatic int log_data(input int j);
        return (j < wr_log.size()) ? wr_log[j].data : -1;
    endfunction

    function automatic int log_tick(input int j);
        return (j < wr_log.size()) ? wr_log[j].tick : -1;
    endfunction

    // One clk: drive, compare against model, advance model on the edge.
    task automatic step();
        if (ce_per == 0) ce = 1'($urandom_range(0, 1));
        else             ce = ((cyc % ce_per) == 0);
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = en[i] && (tail[i] > head[i]);
            req_data[i*DW +: DW]  = (tail[i] > head[i]) ? pbuf[i][head[i] % 64] : 8'h00;
        end
        #1;
        exp_acc = -1;
        if (!rst && ce && m_busy && req_valid[m_owner] && !fifo_full) exp_acc = m_owner;
        chk("wr_en",     int'(fifo_wr_en), int'(exp_acc >= 0));
        chk("req_ready", int'(req_ready), (exp_acc >= 0) ? (1 << exp_acc) : 0);
        chk("rd_en",     int'(fifo_rd_en), int'(!rst && ce && drain_req && !fifo_empty));
        chk("busy",      int'(busy), int'(m_busy));
        chk("owner",     int'(owner), m_owner);
        chk("stall_cnt", int'(stall_cnt), m_stall);
        if (m_busy) chk("wr_data", int'(fifo_wr_data), int'(req_data[m_owner*DW +: DW]));
        if (fifo_wr_en) wr_log.push_back('{int'(owner), int'(fifo_wr_data), tick_idx});
        if (fifo_wr_en && fifo_rd_en) both_seen = 1'b1;
        @(posedge clk);
        if (rst) begin
            m_busy  = 1'b0;
            m_owner = N - 1;
            m_beats = 0;
            m_stall = 0;
        end else if (ce) begin
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_owner + k) % N;
                    if (req_valid[c]) begin
                        m_owner = c;
                        m_busy  = 1'b1;
                        m_beats = 0;
                        break;
                    end
                end
            end else if (!req_valid[m_owner]) begin
                m_busy = 1'b0;
            end else if (fifo_full) begin
                m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            end else begin
                m_beats++;
                if (m_beats == BURST) m_busy = 1'b0;
            end
        end
        if (exp_acc >= 0) head[exp_acc]++;
        if (ce && !rst) tick_idx++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        wr_log.delete();
        tick_idx = 0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (wr_log.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(name, int'(wr_log.size() >= n), 1);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; req_valid = '0; req_data = '0;
        fifo_full = 1'b0; fifo_empty = 1'b1; drain_req = 1'b0;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; en[i] = 1'b0; end
        m_busy = 1'b0; m_owner = N - 1; m_beats = 0; m_stall = 0;
        @(posedge clk);
        @(negedge clk);

        // single producer, ce every 4th clk
        clear_prod();
        ce_per = 4;
        do_reset(2);
        chk("reset_owner", int'(owner), 3);
        chk("reset_busy", int'(busy), 0);
        chk("reset_stall", int'(stall_cnt), 0);
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        repeat (24) step();
        chk("single_count", wr_log.size(), 3);
        chk("single_d0", log_data(0), 8'h11);
        chk("single_d1", log_data(1), 8'h22);
        chk("single_d2", log_data(2), 8'h33);
        chk("single_t0", log_tick(0), 1);
        chk("single_t2", log_tick(2), 3);
        chk("single_stall", int'(stall_cnt), 0);

        // round-robin rotation with one bubble tick per owner change
        ce_per = 1;
        clear_prod();
        do_reset(2);
        for (int p = 0; p < N; p++) for (int w = 0; w < 8; w++) push(p, $urandom_range(0, 255));
        repeat (40) step();
        for (int j = 0; j < 12; j++) begin
            chk($sformatf("rr_owner%0d", j), log_owner(j), j / 4);
            chk($sformatf("rr_tick%0d", j), log_tick(j), 1 + j + j / 4);
        end

        // full stall mid-burst on owner 2
        clear_prod();
        do_reset(2);
        for (int w = 0; w < 6; w++) push(2, 8'hA0 + w);
        wait_writes(2, 20, "stall_pre_writes");
        fifo_full = 1'b1;
        repeat (5) step();
        fifo_full = 1'b0;
        chk("stall_cnt5", int'(stall_cnt), 5);
        chk("stall_no_write", wr_log.size(), 2);
        repeat (12) step();
        chk("stall_total", wr_log.size(), 6);
        chk("stall_gap", log_tick(2) - log_tick(1), 6);
        chk("stall_burst_end", log_tick(4) - log_tick(3), 2);
        chk("stall_owner", log_owner(3), 2);
        chk("stall_d5", log_data(5), 8'hA5);

        // early release by owner 1 while producer 3 waits
        clear_prod();
        do_reset(2);
        for (int w = 0; w < 8; w++) begin push(1, 8'h10 + w); push(3, 8'h30 + w); end
        wait_writes(2, 20, "early_pre_writes");
        chk("early_first_owner", log_owner(0), 1);
        en[1] = 1'b0;
        step();
        en[1] = 1'b1;
        repeat (6) step();
        chk("early_next_owner", log_owner(2), 3);
        chk("early_next_data", log_data(2), 8'h30);

        // read strobe gating by empty, then read alongside write
        clear_prod();
        do_reset(2);
        drain_req = 1'b1;
        fifo_empty = 1'b1;
        for (int w = 0; w < 4; w++) push(0, w + 1);
        step();
        #1;
        chk("rd_blocked_empty", int'(fifo_rd_en), 0);
        fifo_empty = 1'b0;
        both_seen = 1'b0;
        repeat (4) step();
        chk("rd_wr_same_tick", int'(both_seen), 1);
        drain_req = 1'b0;

        // reset during the third beat
        clear_prod();
        do_reset(2);
        for (int w = 0; w < 8; w++) push(0, 8'h50 + w);
        for (int w = 0; w < 8; w++) push(1, 8'h60 + w);
        wait_writes(2, 20, "rst_pre_writes");
        rst = 1'b1;
        #1;
        chk("rst_no_write", int'(fifo_wr_en), 0);
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_owner", int'(owner), 3);
        chk("rst_stall", int'(stall_cnt), 0);
        rst = 1'b0;
        wr_log.delete();
        tick_idx = 0;
        repeat (6) step();
        chk("rst_regrant_owner", log_owner(0), 0);
        chk("rst_regrant_data", log_data(0), 8'h52);

        // randomised traffic
        clear_prod();
        ce_per = 0;
        do_reset(2);
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < N; p++) begin
                if ((tail[p] - head[p]) < 4 && $urandom_range(0, 2) == 0) push(p, $urandom_range(0, 255));
                if ($urandom_range(0, 15) == 0) en[p] = !en[p];
            end
            fifo_full  = ($urandom_range(0, 3) == 0);
            fifo_empty = ($urandom_range(0, 2) == 0);
            drain_req  = 1'($urandom_range(0, 1));
            rst        = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
